// File: rtl/primos_pkg.sv
// Shared definitions for the prime generator and its remainder unit.
//   WIDTH        operand width of the search origin and result
//   MAIOR_PRIMO  largest prime representable in WIDTH bits
//   DIV_CICLOS   cycles the remainder unit spends per division
//   estado_t     search FSM states
//   quadrado()   9-bit divisor squared into 18 bits (cannot overflow)
package primos_pkg;

    localparam int WIDTH       = 16;
    localparam int MAIOR_PRIMO = 65521;
    localparam int DIV_CICLOS  = 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        TEST,
        DIV_WAIT,
        DONE
    } estado_t;

    function automatic logic [17:0] quadrado(input logic [8:0] d);
        logic [17:0] dd;
        dd = {9'd0, d};
        return dd * dd;
    endfunction

endpackage

// File: rtl/resto_seq.sv
// Restoring remainder unit: dividendo mod divisor, one quotient bit per cycle.
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   inicio     load operands and start a division (one-cycle pulse)
//   dividendo  16-bit dividend, sampled with inicio
//   divisor    9-bit non-zero divisor, sampled with inicio
//   resto      remainder, valid while/after pronto
//   pronto     one-cycle pulse after the last quotient bit
module resto_seq
    import primos_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic [15:0] dividendo,
    input  logic [8:0] divisor,
    output logic [8:0] resto,
    output logic       pronto
);

    // Dividend bits leave from the MSB end; quotient bits fill in from the LSB end.
    logic [15:0] quoc_q, quoc_d;
    logic [8:0]  rem_q, rem_d;
    logic [8:0]  dsr_q, dsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        pronto_q, pronto_d;

    logic [9:0]  parcial;
    logic [8:0]  dif;
    logic        cabe;

    always_comb begin
        quoc_d   = quoc_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        pronto_d = 1'b0;

        parcial  = {rem_q, quoc_q[15]};
        cabe     = (parcial >= {1'b0, dsr_q});
        // Only used when cabe=1, so the difference is below the divisor and fits 9 bits.
        dif      = parcial[8:0] - dsr_q;

        if (inicio) begin
            quoc_d = dividendo;
            rem_d  = '0;
            dsr_d  = divisor;
            cnt_d  = 5'(DIV_CICLOS);
        end else if (cnt_q != 5'd0) begin
            quoc_d   = {quoc_q[14:0], cabe};
            rem_d    = cabe ? dif : parcial[8:0];
            cnt_d    = cnt_q - 5'd1;
            pronto_d = (cnt_q == 5'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quoc_q   <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            pronto_q <= 1'b0;
        end else begin
            quoc_q   <= quoc_d;
            rem_q    <= rem_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            pronto_q <= pronto_d;
        end
    end

    assign resto  = rem_q;
    assign pronto = pronto_q;

endmodule

// File: rtl/proximo_primo.sv
// Sequential prime generator: smallest prime P >= N by trial division with odd divisors.
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts a search without a done pulse
//   start  request pulse, sampled only while busy=0
//   N      search origin, captured on the accepted start
//   busy   high from the cycle after accept through the done cycle
//   done   one-cycle pulse when the result is ready
//   found  a prime >= N exists within WIDTH bits (valid with done, held)
//   P      result prime, 0 when found=0 (held until the next result)
//
// state    | meaning
// IDLE     | waiting for start; also hosts the done cycle (busy still high)
// INIT     | clamp candidates below 2 up to 2
// CHECK    | range / two / evenness screening of candidate C
// TEST     | stop when D*D > C, else launch C mod D
// DIV_WAIT | wait for the remainder, then next divisor or next candidate
// DONE     | publish P and found
module proximo_primo
    import primos_pkg::*;
#(
    parameter int WIDTH = primos_pkg::WIDTH
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] P
);

    localparam logic [WIDTH:0] C_UM   = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] C_DOIS = (WIDTH+1)'(2);

    estado_t          state_q, state_d;
    logic [WIDTH:0]   c_q, c_d;
    logic [8:0]       d_q, d_d;
    logic             ok_q, ok_d;
    logic             div_ini_q, div_ini_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [WIDTH-1:0] p_q, p_d;

    logic [8:0]       resto;
    logic             pronto;

    resto_seq u_resto (
        .clk       (clk),
        .reset     (reset),
        .inicio    (div_ini_q),
        .dividendo (c_q[WIDTH-1:0]),
        .divisor   (d_q),
        .resto     (resto),
        .pronto    (pronto)
    );

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        ok_d      = ok_q;
        div_ini_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        found_d   = found_q;
        p_d       = p_q;

        case (state_q)
            IDLE: begin
                // busy_q still set here means this is the done cycle: start is ignored.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    c_d     = {1'b0, N};
                    busy_d  = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (c_q < C_DOIS) c_d = C_DOIS;
                state_d = CHECK;
            end
            CHECK: begin
                if (c_q[WIDTH]) begin
                    ok_d    = 1'b0;
                    state_d = DONE;
                end else if (c_q == C_DOIS) begin
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else if (!c_q[0]) begin
                    c_d = c_q + C_UM;
                end else begin
                    d_d     = 9'd3;
                    state_d = TEST;
                end
            end
            TEST: begin
                if (quadrado(d_q) > 18'(c_q)) begin
                    ok_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    div_ini_d = 1'b1;
                    state_d   = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (pronto) begin
                    if (resto == 9'd0) begin
                        c_d     = c_q + C_DOIS;
                        state_d = CHECK;
                    end else begin
                        d_d     = d_q + 9'd2;
                        state_d = TEST;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                found_d = ok_q;
                p_d     = ok_q ? c_q[WIDTH-1:0] : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            ok_q      <= 1'b0;
            div_ini_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            ok_q      <= ok_d;
            div_ini_q <= div_ini_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            p_q       <= p_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign P     = p_q;

endmodule

// File: doc/proximo_primo.md
# proximo_primo

Sequential prime generator. Given a 16-bit value `N`, it returns the smallest prime P with P ≥ N. It is the generating counterpart of the team's combinational prime detector. Trial division by odd divisors runs through an iterative remainder unit, so the latency depends on the data. The block sits behind a start/done handshake and can feed number-theory demos or the detector's verification bench as a golden sequence source.

## Interface
- `WIDTH`, 16: operand width. Only 16 is verified.
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request pulse. Sampled only while `busy`=0.
- `N` in WIDTH: search origin. Captured on the accepted `start`.
- `busy` out 1: high from the cycle after accept until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when the result is ready.
- `found` out 1: 1 if a prime ≥ N exists within WIDTH bits. Valid with `done`; held afterwards.
- `P` out WIDTH: the result prime, or 0 when `found`=0. Held until the next accepted `start`.

## Operation
- Reset: `busy`=0, `done`=0, `found`=0, `P`=0, FSM in IDLE. A reset during a search aborts it and emits no `done`.
- Candidate register C is WIDTH+1 bits (17). Divisor register D is 9 bits. The D·D comparison is done in 18 bits, so nothing can overflow.
- States and transitions:
  - **IDLE**: if `start`=1, capture C←N and go to INIT. Otherwise stay.
  - **INIT**: if C<2, set C←2. Go to CHECK.
  - **CHECK**:
    - If C>65535, set `found`=0 and go to DONE.
    - If C==2, it is prime; go to DONE.
    - If C is even, set C←C+1 and stay in CHECK.
    - Otherwise set D←3 and go to TEST.
  - **TEST**:
    - If D·D>C, C is prime; go to DONE.
    - Otherwise pulse the divider start and go to DIV_WAIT.
  - **DIV_WAIT**: wait for the divider's `pronto`.
    - If the remainder is 0, set C←C+2 and go to CHECK.
    - Otherwise set D←D+2 and go to TEST.
  - **DONE**: `done`=1. Latch `P` and `found`. Go to IDLE.
- After the first odd candidate, candidates advance by 2. The even check in CHECK runs only once, right after INIT.
- `start` while `busy`=1 is ignored and `N` is not re-sampled.
- `start` in the same cycle as `done` is ignored. It is accepted on the following cycle, when the FSM is in IDLE.

## Timing
- Accept edge: `start` high at edge t moves the FSM to INIT. `busy` is high from t+1.
- N≤2: `done` at edge t+3, after INIT, CHECK and DONE. `P`=2.
- Each divisor trial costs 1 TEST cycle, plus 1 divider start cycle, plus WIDTH divider cycles, plus 1 decision cycle, for 19 cycles in total.
- Worst case is bounded by about 127 divisor trials per candidate times the prime gap (<75 within 16 bits). The bench timeout is 200 000 cycles.
- `P` and `found` update on the same edge at which `done` rises. They are stable for at least 1 cycle before any new accept.
- `done` never rises on two consecutive cycles.

## Structure
- Package `primos_pkg` holds:
  - the state enum: IDLE, INIT, CHECK, TEST, DIV_WAIT, DONE;
  - `WIDTH`=16;
  - `MAIOR_PRIMO`=65521;
  - `DIV_CICLOS`=16.
- Sub-module `resto_seq` is a restoring remainder unit.
  - Ports: `clk`, `reset`, `inicio`, `dividendo[15:0]`, `divisor[8:0]`, `resto[8:0]`, `pronto`.
  - Behaviour: one quotient bit per cycle, 16 cycles, `pronto` pulses once.
  - It is reused unchanged by later arithmetic blocks.
- Expected size: about 180 lines top and about 70 lines for `resto_seq`.

## Test plan
- After reset, no `start`: `busy`=0, `done`=0, `P`=0, `found`=0 for 20 cycles.
- Small values:
  - N=0 gives `P`=2 with `done` at t+3.
  - N=14 gives `P`=17.
  - N=17 gives `P`=17.
  - N=24 gives `P`=29.
  - N=25 gives `P`=29; this case rejects 25 via D=5.
- Upper boundary:
  - N=65521 gives `P`=65521, `found`=1.
  - N=65522 gives `found`=0, `P`=0, with no hang.
  - N=65535 gives the same result as N=65522.
- Handshake: start N=1000, then pulse `start` with N=5 while `busy`. Only one `done` occurs, with `P`=1009. Then start N=5 and get `P`=5.
- Reset mid-search: start N=32000, assert `reset` 50 cycles later. All outputs return to 0 and no `done` appears. A following start with N=90 gives `P`=97.
- Sweep: for N=0..2000 and 500 random N, compare `P` against a model that uses the detector's primality definition. Check that `busy` and `done` follow the rules above.
